// File: rtl/ps2_host_tx.sv
// ps2_host_tx: open-drain PS/2 host-to-device command byte transmitter
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       TX_DONE,
  output logic       TX_ERR,
  output logic       BUSY,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DAT_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DAT_OE
);
  localparam int IW = INHIBIT_CYCLES > 1 ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [2:0] IDLE = 3'd0, INHIBIT = 3'd1, REQ = 3'd2, SHIFT = 3'd3, ACK = 3'd4, WAIT_IDLE = 3'd5;
  logic [2:0] state_q, state_d;
  logic [1:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic clk_prev_q, clk_prev_d;
  logic [8:0] frame_q, frame_d;
  logic [3:0] bit_q, bit_d;
  logic [IW-1:0] inh_q, inh_d;
  logic [TW-1:0] to_q, to_d;
  logic clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d, done_q, done_d, err_q, err_d;
  logic clk_s, dat_s, fall, accept, counting, timed_out;
  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];
  assign fall = clk_prev_q && !clk_s;
  assign TX_READY = state_q == IDLE && !done_q && !err_q;
  assign accept = TX_VALID && TX_READY;
  assign BUSY = state_q != IDLE;
  assign TX_DONE = done_q;
  assign TX_ERR = err_q;
  assign PS2_CLK_OE = clk_oe_q;
  assign PS2_DAT_OE = dat_oe_q;
  always_comb begin
    clk_sync_d = {clk_sync_q[0], PS2_CLK_IN};
    dat_sync_d = {dat_sync_q[0], PS2_DAT_IN};
    clk_prev_d = clk_s;
    counting = state_q inside {SHIFT, ACK, WAIT_IDLE};
    timed_out = counting && to_q == TW'(TIMEOUT_CYCLES - 1);
    inh_d = state_q == INHIBIT ? inh_q + 1'b1 : '0;
    to_d = counting ? to_q + 1'b1 : '0;
    state_d = state_q;
    frame_d = frame_q;
    bit_d = bit_q;
    dat_oe_d = dat_oe_q;
    done_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        state_d = INHIBIT;
        frame_d = {~^TX_DATA, TX_DATA};
        bit_d = '0;
      end
      INHIBIT: if (inh_q == IW'(INHIBIT_CYCLES - 1)) begin
        state_d = REQ;
        dat_oe_d = 1'b1;
      end
      REQ: state_d = SHIFT;
      SHIFT: if (fall) begin
        dat_oe_d = bit_q != 4'd9 && !frame_q[0];
        frame_d = frame_q >> 1;
        bit_d = bit_q + 4'd1;
        state_d = bit_q == 4'd9 ? ACK : SHIFT;
      end
      ACK: if (fall) begin
        state_d = dat_s ? IDLE : WAIT_IDLE;
        err_d = dat_s;
      end
      WAIT_IDLE: if (clk_s && dat_s) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (timed_out) begin
      state_d = IDLE;
      done_d = 1'b0;
      err_d = 1'b1;
    end
    dat_oe_d = state_d == IDLE ? 1'b0 : dat_oe_d;
    clk_oe_d = state_d == INHIBIT || state_d == REQ;
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
      frame_q <= '0;
      bit_q <= '0;
      inh_q <= '0;
      to_q <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_prev_q <= clk_prev_d;
      frame_q <= frame_d;
      bit_q <= bit_d;
      inh_q <= inh_d;
      to_q <= to_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte (for example 0xED set-LEDs, 0xFF reset, 0xF4 enable) from the FPGA to the keyboard on the shared PS2_CLK/PS2_DAT lines. The block drives both lines as open-drain through output-enable pins and runs on the system clock, sampling the device-generated PS/2 clock through a synchronizer. It sits beside the existing PS/2 receive path. The top level combines the OE pins with the pads: each pad is pulled low when its OE is 1 and left high-Z otherwise.

## Interface
Parameters:
- INHIBIT_CYCLES, 5000, number of CLK cycles PS2_CLK is held low before the request (100 µs at 50 MHz).
- TIMEOUT_CYCLES, 750000, abort limit from clock release to bus idle (15 ms at 50 MHz).

Ports:
- CLK  in  1  system clock. This is the block's only clock.
- RST_N  in  1  reset. Synchronous, active-low.
- TX_DATA  in  8  byte to send. Latched on accept.
- TX_VALID  in  1  send request.
- TX_READY  out  1  high only in IDLE. A byte is accepted when TX_VALID and TX_READY are both high on a CLK edge.
- TX_DONE  out  1  one-cycle pulse: the device acknowledged and the bus returned to idle.
- TX_ERR  out  1  one-cycle pulse: no ACK, or timeout.
- BUSY  out  1  high in every state except IDLE.
- PS2_CLK_IN  in  1  raw PS2_CLK pad level (asynchronous).
- PS2_DAT_IN  in  1  raw PS2_DAT pad level (asynchronous).
- PS2_CLK_OE  out  1  1 = drive PS2_CLK low.
- PS2_DAT_OE  out  1  1 = drive PS2_DAT low.

## Operation
Input synchronization:
- PS2_CLK_IN and PS2_DAT_IN each pass through a 2-flop synchronizer.
- fall = previous synced CLK is 1 and current synced CLK is 0. Only synced values are used internally.

States and transitions:
- IDLE: both OE = 0. TX_READY = 1. On accept, latch TX_DATA, compute parity = ~^TX_DATA (odd parity), clear bit index, go to INHIBIT.
- INHIBIT: CLK_OE = 1, DAT_OE = 0 for exactly INHIBIT_CYCLES cycles, then go to REQ.
- REQ: CLK_OE = 1, DAT_OE = 1 (start bit) for 1 cycle, then go to SHIFT. The timeout counter clears here.
- SHIFT: CLK_OE = 0 (clock released). DAT_OE holds the current bit until the next fall. On fall number k:
  - k = 1..8: DAT_OE = ~data[k-1] (LSB first).
  - k = 9: DAT_OE = ~parity.
  - k = 10: DAT_OE = 0 (stop bit, line released). Go to ACK.
- ACK: on the next fall, sample synced DAT. If 0, go to WAIT_IDLE. If 1, pulse TX_ERR and go to IDLE.
- WAIT_IDLE: when synced CLK = 1 and synced DAT = 1 in the same cycle, pulse TX_DONE and go to IDLE.
- Timeout: in SHIFT, ACK and WAIT_IDLE the counter increments every cycle. When it reaches TIMEOUT_CYCLES-1, pulse TX_ERR, set both OE to 0, go to IDLE.

Rules:
- TX_VALID outside IDLE is ignored. No queueing.
- TX_DATA changes after accept have no effect.
- Counter widths are $clog2 of their limit. Counters saturate or wrap only through a state exit.
- If fall and the timeout terminal count occur in the same cycle, the timeout wins.

## Timing
- Reset (RST_N = 0 at a CLK edge): next state IDLE. TX_READY = 1, TX_DONE = 0, TX_ERR = 0, BUSY = 0, PS2_CLK_OE = 0, PS2_DAT_OE = 0, counters 0, synchronizers loaded with 1.
- Reset mid-transfer behaves the same: both lines are released on the very next edge. No TX_ERR pulse.
- Accept edge T: BUSY = 1 and CLK_OE = 1 from T+1. DAT_OE rises at T+1+INHIBIT_CYCLES. CLK_OE falls at T+2+INHIBIT_CYCLES.
- Fall detection lags the pad edge by 2–3 CLK cycles. DAT_OE updates 1 cycle after fall is detected, well within the device's low phase (≥ 30 µs).
- TX_DONE and TX_ERR are registered, exactly one cycle wide, and mutually exclusive.
- TX_READY returns to 1 in the cycle after the DONE or ERR pulse.

## Test plan
- Send 0xED with a device model clocking at 12.5 kHz and ACKing:
  - CLK_OE is low for 5000 cycles, then start bit 0.
  - Device samples bits 1,0,1,1,0,1,1,1, then parity 1, then stop 1.
  - TX_DONE pulses once after both lines go high. Total 11 falls.
- Send 0x01: parity bit 0. Send 0xFF: parity bit 1. Device-sampled frames match in both cases.
- Device never ACKs (DAT high at the 11th fall): TX_ERR pulses 1 cycle, both OE = 0, TX_READY = 1 the cycle after.
- Device never clocks after the request: TX_ERR at exactly TIMEOUT_CYCLES after REQ. Lines released.
- Pulse RST_N low during SHIFT after 4 falls: both OE = 0 on the next edge, BUSY = 0, no DONE or ERR. A subsequent 0xF4 send completes normally.
- Hold TX_VALID high with a changing TX_DATA during a transfer: only the first byte is sent. The second is accepted only after TX_READY returns to 1.
